cache_fill_fsm: RTL and testbench

- Miss-handling engine between the cache arrays and the multi-cycle memory (single-cycle write, 4-cycle pipelined read).
- On a cache miss it issues one read per cycle, on consecutive cycles, for all words of the 16-byte block containing the miss address.
- It counts returning data_valid beats, writes each returned word into the cache data array, and updates the tag array on the last beat.
- One instance sits in front of each cache (I and D); a downstream arbiter selects which one drives memory.

---
 rtl/cache_fill_if.sv | 31 +++
 rtl/cache_fill_fsm.sv | 80 ++++++++
 tb/tb_cache_fill_fsm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_if.sv
// Bus between a cache fill engine and its cache arrays / memory port.
// master = fill engine, slave = cache and memory side.
interface cache_fill_if #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned OFFSET_BITS = 3
);
    logic                   miss_detected;
    logic [ADDR_WIDTH-1:0]  miss_address;
    logic                   memory_data_valid;
    logic [15:0]            memory_data;
    logic                   fsm_busy;
    logic                   mem_enable;
    logic [ADDR_WIDTH-1:0]  memory_address;
    logic                   write_data_array;
    logic                   write_tag_array;
    logic [OFFSET_BITS-1:0] cache_word_offset;
    logic [15:0]            cache_data_out;
    logic                   fill_done;

    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_enable, memory_address, write_data_array, write_tag_array,
               cache_word_offset, cache_data_out, fill_done
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_enable, memory_address, write_data_array, write_tag_array,
               cache_word_offset, cache_data_out, fill_done
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: issues one read per word of the missing block, then counts
// returning beats into the data array and writes the tag on the final beat.
module cache_fill_fsm #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned OFFSET_BITS = 3
) (
    input logic            clk,
    input logic            rst,
    cache_fill_if.master   bus
);
    // Byte-address bit where the block number starts (16-bit words).
    localparam int unsigned BlockLsb = OFFSET_BITS + 1;
    localparam logic [OFFSET_BITS:0] LastIdx = (OFFSET_BITS + 1)'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                       state_q;
    logic [OFFSET_BITS:0]         issue_cnt_q;
    logic [OFFSET_BITS:0]         ret_cnt_q;
    logic [ADDR_WIDTH-1:BlockLsb] base_q;
    logic                         beat;
    logic                         last_beat;
    logic                         unused_miss_offset;

    assign unused_miss_offset = ^bus.miss_address[BlockLsb-1:0];

    assign beat      = (state_q != StIdle) && bus.memory_data_valid;
    assign last_beat = beat && (ret_cnt_q == LastIdx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.miss_detected) begin
                        base_q      <= bus.miss_address[ADDR_WIDTH-1:BlockLsb];
                        issue_cnt_q <= '0;
                        ret_cnt_q   <= '0;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    issue_cnt_q <= issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LastIdx) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: ;
                default: state_q <= StIdle;
            endcase
            if (beat) begin
                ret_cnt_q <= ret_cnt_q + 1'b1;
            end
            // Completion depends only on the beat count, so any memory latency works.
            if (last_beat) begin
                state_q <= StIdle;
            end
        end
    end

    always_comb begin
        bus.fsm_busy          = (state_q != StIdle);
        bus.mem_enable        = (state_q == StIssue);
        bus.memory_address    = '0;
        if (state_q == StIssue) begin
            // Concatenation keeps every request inside the block; no carry.
            bus.memory_address = {base_q, issue_cnt_q[OFFSET_BITS-1:0], 1'b0};
        end
        bus.write_data_array  = beat;
        bus.cache_word_offset = beat ? ret_cnt_q[OFFSET_BITS-1:0] : '0;
        bus.write_tag_array   = last_beat;
        bus.fill_done         = last_beat;
        bus.cache_data_out    = bus.memory_data;
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a pipelined memory model and a write scoreboard.
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_fill_if #(.ADDR_WIDTH(16), .OFFSET_BITS(3)) bus ();

    cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8), .OFFSET_BITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lat         = 4;
    logic        stray = 1'b0;
    logic [15:0] stray_data = 16'hBEEF;

    typedef struct packed {
        logic [2:0]  off;
        logic [15:0] data;
        logic        last;
    } exp_t;
    exp_t sbq[$];

    logic        active     = 1'b0;
    int          fill_start = 0;
    int          fill_lat   = 4;
    int          n_fills    = 0;
    logic [15:0] fill_base  = 16'h0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        w = {1'b0, a[15:1]};
        return (w * 16'd40503) ^ 16'h3C5A;
    endfunction

    // Memory model: read data appears lat cycles after the request; cleared by reset.
    logic        pv[8];
    logic [15:0] pa[8];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 16'h0;
            end
        end else begin
            pv[0] <= bus.mem_enable;
            pa[0] <= bus.memory_address;
            for (int i = 1; i < 8; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    always_comb begin
        bus.memory_data_valid = pv[lat-1] | stray;
        bus.memory_data       = stray ? stray_data : mem_word(pa[lat-1]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.fsm_busy), 32'd0);
        check({tag, "_mem_enable"}, 32'(bus.mem_enable), 32'd0);
        check({tag, "_memory_address"}, 32'(bus.memory_address), 32'd0);
        check({tag, "_write_data"}, 32'(bus.write_data_array), 32'd0);
        check({tag, "_write_tag"}, 32'(bus.write_tag_array), 32'd0);
        check({tag, "_offset"}, 32'(bus.cache_word_offset), 32'd0);
        check({tag, "_fill_done"}, 32'(bus.fill_done), 32'd0);
    endtask

    // One clock cycle: drive inputs, then compare outputs with the timing model and scoreboard.
    task automatic cycle(input logic miss, input logic [15:0] addr, input logic stray_in);
        int   rel;
        logic e_busy, e_men, e_wr;
        exp_t e;
        @(negedge clk);
        cyc++;
        bus.miss_detected = miss;
        bus.miss_address  = addr;
        stray             = stray_in;
        #1;
        rel    = active ? cyc - fill_start : 0;
        e_busy = active && rel >= 1 && rel <= 8 + fill_lat;
        e_men  = active && rel >= 1 && rel <= 8;
        e_wr   = active && rel >= fill_lat + 1 && rel <= fill_lat + 8;
        check("fsm_busy", 32'(bus.fsm_busy), 32'(e_busy));
        check("mem_enable", 32'(bus.mem_enable), 32'(e_men));
        check("cache_data_out", 32'(bus.cache_data_out), 32'(bus.memory_data));
        if (e_men)
            check("memory_address", 32'(bus.memory_address), 32'(fill_base + 16'(2 * (rel - 1))));
        if (e_wr) begin
            check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("write_data_array", 32'(bus.write_data_array), 32'd1);
                check("word_offset", 32'(bus.cache_word_offset), 32'(e.off));
                check("fill_data", 32'(bus.cache_data_out), 32'(e.data));
                check("write_tag_array", 32'(bus.write_tag_array), 32'(e.last));
                check("fill_done", 32'(bus.fill_done), 32'(e.last));
            end
        end else begin
            check("write_data_idle", 32'(bus.write_data_array), 32'd0);
            check("write_tag_idle", 32'(bus.write_tag_array), 32'd0);
            check("fill_done_idle", 32'(bus.fill_done), 32'd0);
        end
        if (e_busy && rel == 8 + fill_lat) active = 1'b0;
        if (miss && !e_busy && !rst) begin
            active     = 1'b1;
            fill_start = cyc;
            fill_lat   = lat;
            fill_base  = {addr[15:4], 4'h0};
            n_fills++;
            for (int k = 0; k < 8; k++)
                sbq.push_back('{off: 3'(k), data: mem_word(fill_base + 16'(2 * k)),
                                last: (k == 7)});
        end
    endtask

    task automatic run_fill(input logic [15:0] addr, input int idle_after);
        cycle(1'b1, addr, 1'b0);
        for (int i = 0; i < 8 + lat + idle_after; i++) cycle(1'b0, 16'h0, 1'b0);
        check("sb_drained", 32'(sbq.size()), 32'd0);
    endtask

    int first_start;
    int fills_before;

    initial begin
        bus.miss_detected = 1'b0;
        bus.miss_address  = 16'h0;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        cycle(1'b0, 16'h0, 1'b0);
        rst = 1'b0;

        // Basic fill from 0x1236, 4-cycle memory
        run_fill(16'h1236, 2);
        // Top-of-memory block: no wrap past 0xFFFE
        run_fill(16'hFFFA, 1);

        // Miss held for 20 cycles: exactly two back-to-back fills
        fills_before = n_fills;
        cycle(1'b1, 16'h0A46, 1'b0);
        first_start = fill_start;
        for (int i = 1; i < 20; i++) cycle(1'b1, 16'h0A46, 1'b0);
        check("second_accept_cycle", 32'(fill_start - first_start), 32'd13);
        for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0, 1'b0);
        check("held_miss_fills", 32'(n_fills - fills_before), 32'd2);
        check("held_sb_drained", 32'(sbq.size()), 32'd0);

        // Stray valid beats while idle must not write anything
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'(i % 2 == 0));
        run_fill(16'h5550, 1);

        // Asynchronous reset in cycle 7 of a fill
        cycle(1'b1, 16'h2468, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 16'h0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        active = 1'b0;
        sbq.delete();
        cycle(1'b0, 16'h0, 1'b0);
        check_all_zero("reset_held");
        rst = 1'b0;
        cycle(1'b0, 16'h0, 1'b0);
        run_fill(16'h2468, 1);

        // Single-cycle memory latency: 9 busy cycles
        lat = 1;
        run_fill(16'h3C8E, 2);
        lat = 4;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
